// File: rtl/cpu_div_pkg.sv
// ---------------------------------------------------------------------------
// cpu_div_pkg
// Shared definitions for the multicycle divider (seq_divider / div_step).
//   DIV_WIDTH  : operand/result width used by the CPU datapath.
//   DIV_CNT_W  : width of the iteration counter (one count per quotient bit).
//   div_state_e: divider control states.
// ---------------------------------------------------------------------------
package cpu_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    FIX   = 2'd3
  } div_state_e;

endpackage : cpu_div_pkg

// File: rtl/seq_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes.
// The {remainder, quotient} pair is shifted left by one, the divisor is
// trial-subtracted from the widened remainder, and the result is kept (with
// a 1 shifted into the quotient) only when it did not go negative.
//
// Ports:
//   i_rem  [WIDTH-1:0] partial remainder before the step
//   i_quo  [WIDTH-1:0] quotient/dividend shift register before the step
//   i_dvs  [WIDTH-1:0] divisor magnitude (non-zero)
//   o_rem  [WIDTH-1:0] partial remainder after the step
//   o_quo  [WIDTH-1:0] quotient shift register after the step
// ---------------------------------------------------------------------------
module div_step
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // The shifted remainder needs one extra bit: it can reach 2*divisor-1,
  // which overflows WIDTH bits for divisors above 2^(WIDTH-1).
  logic [WIDTH:0] w_shift_rem;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  assign w_shift_rem = {i_rem, i_quo[WIDTH-1]};
  assign w_trial     = w_shift_rem - {1'b0, i_dvs};
  // The MSB of the widened difference acts as the borrow/sign bit.
  assign w_fits      = ~w_trial[WIDTH];

  assign o_rem = w_fits ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule : div_step

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multicycle signed restoring divider for div/divm. Operands are converted
// to magnitudes on start, WIDTH restoring steps produce the unsigned
// quotient/remainder, and a final fix-up cycle applies the signs:
// quotient truncates toward zero, remainder takes the dividend's sign.
//
// Timeline (edge 0 samples start in IDLE):
//   edge 0          : latch magnitudes and signs, busy goes high
//   edge 1          : zero-divisor check (div_zero pulse, back to IDLE)
//   edges 2..W+1    : one restoring step per edge
//   edge W+2        : write hi/lo, done pulse, busy low
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        one-cycle request, sampled only in IDLE
//   op_unsigned  (only with SEQ_DIVIDER_UNSIGNED_EN) divu semantics
//   dividend     numerator, two's complement
//   divisor      denominator, two's complement
//   busy         operation in flight
//   done         one-cycle pulse, hi/lo valid from this cycle
//   div_zero     one-cycle pulse, divisor was zero (hi/lo untouched)
//   hi           remainder register
//   lo           quotient register
//
// Build option: define SEQ_DIVIDER_UNSIGNED_EN to add the op_unsigned input.
// ---------------------------------------------------------------------------
module seq_divider
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_counter;
  logic [WIDTH-1:0] r_rem;       // partial remainder
  logic [WIDTH-1:0] r_quo;       // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] r_dvs;       // divisor magnitude
  logic             r_neg_a;     // dividend was negative (signed op)
  logic             r_neg_b;     // divisor was negative (signed op)
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_op_unsigned;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign w_op_unsigned = op_unsigned;
`else
  assign w_op_unsigned = 1'b0;
`endif

  // Unsigned operations treat the sign bit as magnitude, so the sign flags
  // are forced low and the fix-up cycle negates nothing.
  assign w_neg_a = dividend[WIDTH-1] & ~w_op_unsigned;
  assign w_neg_b = divisor[WIDTH-1]  & ~w_op_unsigned;

  // WIDTH-bit negation: the most negative value maps onto itself, which is
  // the exact magnitude when read as unsigned.
  assign w_dvd_mag = w_neg_a ? -dividend : dividend;
  assign w_dvs_mag = w_neg_b ? -divisor  : divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_counter  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      // Status pulses last exactly one cycle unless re-asserted below.
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_quo   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_busy  <= 1'b1;
            r_state <= CHECK;
          end
        end

        CHECK: begin
          if (r_dvs == '0) begin
            r_div_zero <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_rem     <= '0;
            r_counter <= '0;
            r_state   <= ITER;
          end
        end

        ITER: begin
          r_rem     <= w_step_rem;
          r_quo     <= w_step_quo;
          r_counter <= r_counter + CNT_W'(1);
          if (r_counter == LAST_STEP) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          r_lo    <= (r_neg_a ^ r_neg_b) ? -r_quo : r_quo;
          r_hi    <= r_neg_a ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (default signed build): a table of
// fixed vectors, hand-written multi-cycle corner sequences and randomized
// operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W        = 32;
  localparam int LATENCY  = W + 2;   // edges from start sample to done
  localparam int MAX_WAIT = 60;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  // Expected hi/lo held by the bench (what the last completed op produced).
  logic [W-1:0] m_lo;
  logic [W-1:0] m_hi;

  seq_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: MIPS div semantics from plain 64-bit signed arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = W'(sa / sb);
    r  = W'(sa % sb);
  endfunction

  // Issue one operation (start sampled on the next edge = edge 0), wait for
  // done/div_zero and compare. If intrude > 0, start is pulsed again with
  // 9/3 so that edge number 'intrude' samples it. Returns just after the
  // completion edge, so a caller can start the next op in the done cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic exp_dz, input logic [W-1:0] exp_lo,
                       input logic [W-1:0] exp_hi, input int intrude,
                       input string tag);
    int n;
    bit seen;
    bit both;
    bit late_done;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_edge0"}, 64'(busy), 64'd1);
    check({tag, "_prev_pulse_fall"}, 64'({done, div_zero}), 64'd0);
    n = 0; seen = 0; both = 0;
    while (!seen && n < MAX_WAIT) begin
      if (intrude > 0 && n + 1 == intrude) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done && div_zero) both = 1;
      if (done || div_zero) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_latency"}, 64'(n), exp_dz ? 64'd1 : 64'(LATENCY));
      check({tag, "_done"}, 64'(done), exp_dz ? 64'd0 : 64'd1);
      check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
      check({tag, "_both"}, 64'(both), 64'd0);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
      check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    end
    if (exp_dz) begin
      late_done = 0;
      repeat (LATENCY + 2) begin
        @(posedge clk); #1;
        if (done) late_done = 1;
      end
      check({tag, "_no_done_after_dz"}, 64'(late_done), 64'd0);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rdz;
    int           mode;
    bit           any_pulse;

    vecs[0]  = '{32'd100,      32'd7,        32'h0000000E, 32'h00000002, 1'b0};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[5]  = '{32'h80000000, 32'd1,        32'h80000000, 32'h00000000, 1'b0};
    vecs[6]  = '{32'd7,        32'd100,      32'h00000000, 32'h00000007, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{32'd0,        32'd5,        32'h00000000, 32'h00000000, 1'b0};
    vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b0};
    vecs[10] = '{32'd5,        32'd0,        32'h00000000, 32'h7FFFFFFF, 1'b1};

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",     64'(busy),     64'd0);
    check("reset_done",     64'(done),     64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    check("reset_hi",       64'(hi),       64'd0);
    check("reset_lo",       64'(lo),       64'd0);
    reset = 1'b0;
    m_lo = '0; m_hi = '0;
    @(posedge clk); #1;

    // Fixed vectors.
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].dz, vecs[i].lo, vecs[i].hi, 0,
            $sformatf("vec%0d", i));
      repeat (2) @(posedge clk);
      #1;
    end
    m_lo = 32'h00000000; m_hi = 32'h7FFFFFFF;

    // Preload 14/2, then divide by zero: hi/lo must survive.
    do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, "preload");
    do_op(32'd5,   32'd0, 1'b1, 32'd14, 32'd2, 0, "dz_keep");

    // Start during busy at edge 5 is ignored; then a back-to-back start in
    // the done cycle is accepted.
    do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 5, "intrude");
    do_op(32'd9,   32'd3, 1'b0, 32'd3,  32'd0, 0, "back2back");

    // Reset between edges 10 and 11 of an operation.
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_busy",     64'(busy),     64'd0);
    check("midreset_done",     64'(done),     64'd0);
    check("midreset_div_zero", 64'(div_zero), 64'd0);
    check("midreset_hi",       64'(hi),       64'd0);
    check("midreset_lo",       64'(lo),       64'd0);
    @(negedge clk);
    reset = 1'b0;
    any_pulse = 0;
    repeat (LATENCY + 6) begin
      @(posedge clk); #1;
      if (done || div_zero || busy) any_pulse = 1;
    end
    check("midreset_abandoned", 64'(any_pulse), 64'd0);
    m_lo = '0; m_hi = '0;

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 4));
      ra   = $urandom;
      case (mode)
        0:       rb = '0;
        1:       rb = ($urandom_range(0, 1) == 1) ? -W'($urandom_range(1, 15))
                                                  : W'($urandom_range(1, 15));
        2:       begin rb = $urandom; ra = W'($urandom_range(0, 1000)); end
        default: rb = $urandom;
      endcase
      rdz = (rb == '0);
      if (!rdz) begin
        ref_div(ra, rb, rq, rr);
        m_lo = rq; m_hi = rr;
      end
      do_op(ra, rb, rdz, m_lo, m_hi, 0, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle signed 32-bit restoring divider for the CPU datapath, serving div/divm.
- Operands arrive from the divider source-A mux (A or MDR) and register B.
- Produces quotient (LO) and remainder (HI) for the HI/LO input muxes, plus a divide-by-zero flag for the control unit's exception path.
- Driven by a one-cycle start pulse from the control unit; signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is required to work in the CPU.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- dividend  input  WIDTH  numerator, two's complement.
- divisor  input  WIDTH  denominator, two's complement.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle onward.
- div_zero  output  1  one-cycle pulse; divisor was zero.
- hi  output  WIDTH  remainder register.
- lo  output  WIDTH  quotient register.

Behaviour:
- Reset (asynchronous, active-high), any state, including mid-operation:
  - state=IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0.
  - Any in-flight operation is abandoned; no done pulse follows.
- State machine: IDLE -> CHECK -> ITER -> FIX -> IDLE.
- Edge numbering: edge 0 is the edge that samples start=1 in IDLE.
- Edge 0 (IDLE, start=1):
  - Latch |dividend| and |divisor| into unsigned working registers; latch both sign bits.
  - busy<=1, state<=CHECK.
  - start=0 in IDLE: remain in IDLE.
- Edge 1 (CHECK):
  - If the latched divisor is 0: div_zero<=1, busy<=0, state<=IDLE. hi/lo keep their previous values.
  - Otherwise: clear the partial remainder, counter<=0, state<=ITER.
- Edges 2..WIDTH+1 (ITER): one restoring step per edge.
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quotient bit 0; otherwise restore.
  - Counter increments each step; after step WIDTH-1, state<=FIX.
- Edge WIDTH+2 (FIX):
  - lo <= quotient, negated if the operand signs differ.
  - hi <= remainder, negated if the dividend was negative.
  - done<=1, busy<=0, state<=IDLE.
- Latency:
  - done pulse occupies the cycle after edge WIDTH+2 (edge 34 for WIDTH=32).
  - div_zero pulse occupies the cycle after edge 1.
- Pulse rules: done and div_zero fall on the following edge; they are never high simultaneously.
- Arithmetic:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend (MIPS semantics).
  - Magnitudes use WIDTH-bit unsigned arithmetic, so |0x80000000| = 0x80000000 is exact.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no overflow flag).
- start while busy: ignored; operand inputs are not re-sampled.
- start in the done cycle: accepted, since the state is already IDLE.
- hi/lo hold their last results until the next FIX edge or reset.

Optional Feature:
- Macro: SEQ_DIVIDER_UNSIGNED_EN.
- Defined:
  - Adds input port op_unsigned (1 bit), sampled together with start.
  - When 1, operands are taken as unsigned magnitudes without absolute-value conversion, and FIX applies no negation (divu semantics).
  - 0xFFFFFFFF / 2 gives lo=0x7FFFFFFF, hi=1.
- Undefined: port absent; every operation is signed.

Decomposition:
- Package cpu_div_pkg:
  - State enum (IDLE, CHECK, ITER, FIX).
  - DIV_WIDTH=32.
  - Counter width localparam $clog2(DIV_WIDTH).
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, quotient, divisor magnitude.
  - Outputs: next remainder, next quotient.
  - Instantiated once inside seq_divider.

Test Plan:
- dividend=100, divisor=7, start at edge 0 -> done after edge 34, lo=14 (0x0000000E), hi=2; busy high on edges 0..33.
- dividend=-100 (0xFFFFFF9C), divisor=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); 100/-7 -> lo=-14, hi=2.
- Preload hi=2/lo=14 from a prior op; dividend=5, divisor=0 -> div_zero pulse after edge 1, busy=0 after edge 1, done never rises, hi/lo unchanged.
- dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0 after edge 34.
- Start 100/7, assert reset between edges 10 and 11 -> busy, hi, lo, done drop to 0 immediately; no done pulse ever follows.
- Start 100/7, pulse start again at edge 5 with 9/3 -> ignored, result is lo=14/hi=2; back-to-back start in the done cycle with 9/3 -> lo=3, hi=0, WIDTH+2 edges later.
